// File: rtl/musical_score_record.sv
// Score writer: latches the player's note once per beat and writes it to the
// score RAM at {song_id, beat}, closing each take with an END word.
module musical_score_record #(
    parameter int                 NOTE_W    = 4,
    parameter int                 BEAT_W    = 10,
    parameter int                 MAX_BEATS = 1023,
    parameter logic [NOTE_W-1:0]  REST_CODE = 4'h0,
    parameter logic [NOTE_W-1:0]  END_CODE  = 4'hF
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [1:0]             song_id_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   beat_tick_i,
    input  logic [NOTE_W-1:0]      note_in_i,
    input  logic                   note_valid_i,
    output logic                   wr_en_o,
    output logic [BEAT_W+1:0]      wr_addr_o,
    output logic [NOTE_W-1:0]      wr_data_o,
    output logic [16*NOTE_W-1:0]   recent_notes_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [BEAT_W-1:0]      length_o
);

    localparam int RN_W = 16 * NOTE_W;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_RECORD = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [BEAT_W-1:0] LAST_NOTE_IDX = BEAT_W'(MAX_BEATS - 1);

    logic [2:0]          state_q,   state_d;
    logic [1:0]          song_q,    song_d;
    logic [BEAT_W-1:0]   beat_q,    beat_d;
    logic [NOTE_W-1:0]   latch_q,   latch_d;
    logic                wr_en_q,   wr_en_d;
    logic [BEAT_W+1:0]   wr_addr_q, wr_addr_d;
    logic [NOTE_W-1:0]   wr_data_q, wr_data_d;
    logic [RN_W-1:0]     recent_q,  recent_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [BEAT_W-1:0]   length_q,  length_d;
    logic [NOTE_W-1:0]   beat_note_s;

    // A note arriving with the tick still belongs to the beat being closed.
    assign beat_note_s = note_valid_i ? note_in_i : latch_q;

    // Next-state and write-port decode for the take sequencer.
    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        beat_d    = beat_q;
        latch_d   = latch_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        recent_d  = recent_q;
        length_d  = length_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d  = S_ARMED;
                    song_d   = song_id_i;
                    beat_d   = '0;
                    recent_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_ARMED: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (beat_tick_i) begin
                    state_d = S_RECORD;
                    latch_d = REST_CODE;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_RECORD: begin
                if (beat_tick_i) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {song_q, beat_q};
                    wr_data_d = beat_note_s;
                    beat_d    = beat_q + 1'b1;
                    latch_d   = REST_CODE;
                    recent_d  = {recent_q[RN_W-NOTE_W-1:0], beat_note_s};
                    // Auto-stop keeps the END word inside the song slot.
                    if (stop_i || (beat_q == LAST_NOTE_IDX)) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_RECORD;
                    end
                end else if (stop_i) begin
                    state_d = S_FLUSH;
                end else if (note_valid_i) begin
                    latch_d = note_in_i;
                end else begin
                    latch_d = latch_q;
                end
            end
            S_FLUSH: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {song_q, beat_q};
                wr_data_d = END_CODE;
                length_d  = beat_q;
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_ARMED) || (state_d == S_RECORD) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any take in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            song_q    <= 2'd0;
            beat_q    <= '0;
            latch_q   <= REST_CODE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            recent_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            length_q  <= '0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            beat_q    <= beat_d;
            latch_q   <= latch_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            recent_q  <= recent_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            length_q  <= length_d;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign recent_notes_o = recent_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign length_o       = length_q;

endmodule
